multicycle_control: RTL and testbench

- Control FSM for the multicycle LEGv8 core. It sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- It drives the datapath select and enable lines, and handshakes with a shared instruction/data memory port.
- Supported instructions: LDUR, STUR, CBZ, and R-type ADD/SUB/AND/ORR.
- It also counts retired instructions and flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multicycle LEGv8 core: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with the shared memory port, counts retirements and flags faults.
module multicycle_control #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic             illegal,
  output logic             fault,
  output logic [2:0]       state
);

  localparam int unsigned WaitW       = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam int unsigned WaitLastInt = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;
  localparam logic [WaitW-1:0] WaitLast = WaitLastInt[WaitW-1:0];

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StFault  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsNone  = 3'd0,
    ClsLdur  = 3'd1,
    ClsStur  = 3'd2,
    ClsCbz   = 3'd3,
    ClsRtype = 3'd4
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, dec_cls;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             waiting;

  always_comb begin
    dec_cls = ClsNone;
    if (op == 11'b11111000010) begin
      dec_cls = ClsLdur;
    end else if (op == 11'b11111000000) begin
      dec_cls = ClsStur;
    end else if (op[10:3] == 8'b10110100) begin
      dec_cls = ClsCbz;
    end else if (op == 11'b10001011000 || op == 11'b11001011000 ||
                 op == 11'b10001010000 || op == 11'b10101010000) begin
      dec_cls = ClsRtype;
    end
  end

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    waiting    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end else begin
          waiting = 1'b1;
        end
      end
      StDecode: begin
        cls_d   = dec_cls;
        reg2loc = (dec_cls == ClsStur) || (dec_cls == ClsCbz);
        if (dec_cls == ClsNone) begin
          illegal = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        unique case (cls_q)
          ClsLdur: begin
            alu_src = 1'b1;
            state_d = StMem;
          end
          ClsStur: begin
            alu_src = 1'b1;
            reg2loc = 1'b1;
            state_d = StMem;
          end
          ClsRtype: begin
            alu_op  = 2'b10;
            state_d = StWb;
          end
          ClsCbz: begin
            alu_op   = 2'b01;
            reg2loc  = 1'b1;
            pc_src   = 1'b1;
            pc_write = zero;
            retire   = 1'b1;
            state_d  = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMem: begin
        iord = 1'b1;
        if (cls_q == ClsStur) begin
          mem_write = 1'b1;
          reg2loc   = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_ready) begin
          if (cls_q == ClsStur) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == ClsLdur);
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StFault: fault = 1'b1;
      default: state_d = StFetch;
    endcase

    if (waiting && (WAIT_LIMIT != 0) && (wait_q == WaitLast)) begin
      state_d = StFault;
    end

    // Holding reset drops any in-flight request without waiting for a clock edge.
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg2loc    = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      fault      = 1'b0;
    end
  end

  // Any cycle not spent waiting clears the counter, which covers entry to FETCH and MEM.
  assign wait_d = waiting ? wait_q + 1'b1 : '0;
  assign state  = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      cls_q        <= ClsNone;
      wait_q       <= '0;
      retire_count <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      if (retire) begin
        retire_count <= retire_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle stimulus and expected output
// vectors are queued, then replayed and compared one clock at a time.
module tb_multicycle_control;

  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpCbz  = 11'b10110100101;
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] op;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg2loc, alu_src;
  logic [1:0]  alu_op;
  logic        mem_to_reg, reg_write, retire, illegal, fault;
  logic [31:0] retire_count;
  logic [2:0]  state;

  typedef struct packed {
    logic [10:0] op;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } row_t;

  row_t        sq[$];
  row_t        r;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 0;
  logic [17:0] got;

  multicycle_control #(.CNT_W(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src),
    .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
    .retire_count(retire_count), .illegal(illegal), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] obs();
    return {state, mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg2loc, alu_src,
            alu_op, mem_to_reg, reg_write, retire, illegal, fault};
  endfunction

  // Field order: state, mem_read, mem_write, iord, ir_write, pc_write, pc_src, reg2loc,
  // alu_src, alu_op, mem_to_reg, reg_write, retire, illegal, fault.
  function automatic logic [17:0] ev(input logic [2:0] s, input logic mr, input logic mw,
                                     input logic io, input logic irw, input logic pcw,
                                     input logic pcs, input logic r2l, input logic asr,
                                     input logic [1:0] aop, input logic m2r, input logic rw,
                                     input logic ret, input logic ill, input logic flt);
    return {s, mr, mw, io, irw, pcw, pcs, r2l, asr, aop, m2r, rw, ret, ill, flt};
  endfunction

  task automatic push(input logic [10:0] o, input logic z, input logic rdy,
                      input logic [17:0] e);
    sq.push_back('{op: o, z: z, rdy: rdy, exp: e});
  endtask

  task automatic push_fetch(input logic [10:0] o);
    push(o, 1'b0, 1'b1, ev(3'd0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    reset = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    total++;
    got = obs();
    if (got !== ev(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset_held outputs got=%h exp=%h", got, 18'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    got = obs();
    if (got !== ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset_fetch outputs got=%h exp=%h", got,
               ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    end
    total++;
    if (retire_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d exp=0", retire_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ldur();
    int i = 0;
    push_fetch(OpLdur);
    push(OpLdur, 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    push(OpLdur, 0, 1, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    push(OpLdur, 0, 1, ev(3'd3, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    push(OpLdur, 0, 1, ev(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1, 0, 0));
    exp_cnt = exp_cnt + 1;
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL ldur[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL ldur_count got=%0d exp=%0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_stur_wait();
    int i = 0;
    push_fetch(OpStur);
    push(OpStur, 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    push(OpStur, 0, 1, ev(3'd2, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      push(OpStur, 0, 0, ev(3'd3, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    end
    push(OpStur, 0, 1, ev(3'd3, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0));
    exp_cnt = exp_cnt + 1;
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL stur[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL stur_count got=%0d exp=%0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_cbz();
    int i = 0;
    for (int k = 0; k < 2; k++) begin
      logic zv;
      zv = (k == 0);
      push_fetch(OpCbz);
      push(OpCbz, zv, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0));
      push(OpCbz, zv, 1, ev(3'd2, 0, 0, 0, 0, zv, 1, 1, 0, 2'b01, 0, 0, 1, 0, 0));
      exp_cnt = exp_cnt + 1;
    end
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL cbz[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL cbz_count got=%0d exp=%0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_add_illegal();
    int i = 0;
    push_fetch(OpAdd);
    push(OpAdd, 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    push(OpAdd, 0, 1, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
    push(OpAdd, 0, 1, ev(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0));
    exp_cnt = exp_cnt + 1;
    push_fetch(11'd0);
    push(11'd0, 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0));
    push(11'd0, 0, 0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL add_illegal[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL illegal_count got=%0d exp=%0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] ops [3];
    int i = 0;
    ops[0] = OpSub; ops[1] = OpAnd; ops[2] = OpOrr;
    for (int k = 0; k < 3; k++) begin
      push(ops[k], 0, 0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      push_fetch(ops[k]);
      push(ops[k], 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      push(ops[k], 0, 1, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0));
      push(ops[k], 0, 1, ev(3'd4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 0));
      exp_cnt = exp_cnt + 1;
    end
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=%0d", retire_count, exp_cnt);
    end
  endtask

  task automatic test_fault();
    int i = 0;
    for (int k = 0; k < 4; k++) begin
      push(OpLdur, 0, 0, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    end
    for (int k = 0; k < 3; k++) begin
      push(OpLdur, 0, 1, ev(3'd5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    end
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL fault[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL fault_count got=%0d exp=%0d", retire_count, exp_cnt);
    end
    reset = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || fault !== 1'b0 || mem_read !== 1'b1 || iord !== 1'b0) begin
      bad++;
      $display("FAIL fault_reset got state=%0d fault=%b mem_read=%b iord=%b exp 0/0/1/0",
               state, fault, mem_read, iord);
    end
    total++;
    if (retire_count !== exp_cnt) begin
      bad++;
      $display("FAIL fault_reset_count got=%0d exp=0", retire_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    int i = 0;
    push_fetch(OpLdur);
    push(OpLdur, 0, 1, ev(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    push(OpLdur, 0, 1, ev(3'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
    push(OpLdur, 0, 0, ev(3'd3, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    while (sq.size() > 0) begin
      r = sq.pop_front();
      op = r.op; zero = r.z; mem_ready = r.rdy;
      @(negedge clk);
      total++;
      got = obs();
      if (got !== r.exp) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%h exp=%h", i, got, r.exp);
      end
      i++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (mem_read !== 1'b0 || iord !== 1'b0 || state !== 3'd0 || reg_write !== 1'b0 ||
        retire !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async got mem_read=%b iord=%b state=%0d rw=%b ret=%b exp 0",
               mem_read, iord, state, reg_write, retire);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      got = obs();
      if (got !== ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0) ||
          retire_count !== 32'd0) begin
        bad++;
        $display("FAIL reset_mid_after[%0d] got=%h cnt=%0d exp=%h cnt=0", k, got,
                 retire_count, ev(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_ldur();
    test_stur_wait();
    test_cbz();
    test_add_illegal();
    test_back_to_back();
    test_fault();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
